sram_arbiter_wb8: RTL

- Single-port external async SRAM (512K x 8) controller and arbiter. It sits directly upstream of the VGA framebuffer stage and serves that stage's byte-fetch requests (req/adr in, dat out) with absolute priority.
- Also serves CPU byte accesses through an 8-bit Wishbone B4 classic slave.
- Owns all SRAM pins; the VGA stage and the CPU never touch the SRAM directly.

---
 rtl/sram_arbiter_wb8_pkg.sv | 20 ++
 rtl/sram_arbiter_wb8_sync_edge_detect.sv | 27 ++
 rtl/sram_arbiter_wb8.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_wb8_pkg.sv
// Shared definitions for the SRAM arbiter slice.
//   state_t      arbiter FSM state encoding
//   SRAM_ADR_W   external SRAM address width (512K x 8)
//   FB_BASE      default framebuffer base address used by the video stage
package sram_arbiter_wb8_pkg;

   localparam int SRAM_ADR_W = 19;

   localparam logic [SRAM_ADR_W-1:0] FB_BASE = 19'h2_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VID_RD,
      ST_CPU_RD,
      ST_CPU_WR,
      ST_CPU_WR_HOLD,
      ST_CPU_ACK
   } state_t;

endpackage

// File: rtl/sram_arbiter_wb8_sync_edge_detect.sv
// Two-flop synchroniser followed by a rising-edge detector, for bringing
// a strobe from a foreign clock domain into clk_sys.
//   clk_sys     destination clock
//   rst         asynchronous reset, active-high
//   async_in    strobe from the foreign domain
//   edge_pulse  one clk_sys cycle pulse per rising edge of async_in
module sync_edge_detect (
   input  logic clk_sys,
   input  logic rst,
   input  logic async_in,
   output logic edge_pulse
);

   // [0],[1] are the synchroniser; [2] is the previous synchronised value
   logic [2:0] sync_q;

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], async_in};
      end
   end

   assign edge_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/sram_arbiter_wb8.sv
// Async SRAM (512K x 8) controller and arbiter. Video byte fetches from
// the VGA stage take absolute priority over CPU accesses arriving on an
// 8-bit Wishbone B4 classic slave. All SRAM pins are owned here.
//   CLK_I/RST_I                  system clock, async active-high reset
//   ADR_I/DAT_I/STB_I/WE_I       Wishbone request
//   ACK_O/DAT_O                  Wishbone response (ACK is a 1-cycle pulse)
//   I_vid_req/I_vid_adr          video fetch request (foreign clock domain)
//   O_vid_dat                    last video byte read
//   O_sram_*/I_sram_dat          SRAM address, data, pad enable, strobes
//
// state          | meaning
// ---------------+--------------------------------------------------
// ST_IDLE        | no access; arbitrate video vs CPU
// ST_VID_RD      | video read, ce_n/oe_n low for SRAM_CYCLES cycles
// ST_CPU_RD      | CPU read, ce_n/oe_n low for SRAM_CYCLES cycles
// ST_CPU_WR      | CPU write, ce_n/we_n low for SRAM_CYCLES cycles
// ST_CPU_WR_HOLD | we_n released, data/address held one cycle
// ST_CPU_ACK     | ACK_O high for one cycle
module sram_arbiter_wb8
   import sram_arbiter_wb8_pkg::*;
#(
   parameter int SRAM_CYCLES = 1,
   parameter int ADR_W       = SRAM_ADR_W
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic [ADR_W-1:0] ADR_I,
   input  logic [7:0]       DAT_I,
   input  logic             STB_I,
   input  logic             WE_I,
   output logic             ACK_O,
   output logic [7:0]       DAT_O,
   input  logic             I_vid_req,
   input  logic [ADR_W-1:0] I_vid_adr,
   output logic [7:0]       O_vid_dat,
   output logic [ADR_W-1:0] O_sram_adr,
   output logic [7:0]       O_sram_dat,
   output logic             O_sram_dat_oe,
   input  logic [7:0]       I_sram_dat,
   output logic             O_sram_ce_n,
   output logic             O_sram_oe_n,
   output logic             O_sram_we_n
);

   localparam logic [2:0] CNT_INIT = 3'(SRAM_CYCLES - 1);

   state_t           state;
   logic [2:0]       cnt;
   logic             vid_edge;
   logic             vid_pending;
   logic [ADR_W-1:0] vid_adr;

   sync_edge_detect u_vid_sync (
      .clk_sys    (CLK_I),
      .rst        (RST_I),
      .async_in   (I_vid_req),
      .edge_pulse (vid_edge)
   );

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state         <= ST_IDLE;
         cnt           <= 3'd0;
         vid_pending   <= 1'b0;
         vid_adr       <= '0;
         ACK_O         <= 1'b0;
         DAT_O         <= 8'h00;
         O_vid_dat     <= 8'h00;
         O_sram_adr    <= '0;
         O_sram_dat    <= 8'h00;
         O_sram_dat_oe <= 1'b0;
         O_sram_ce_n   <= 1'b1;
         O_sram_oe_n   <= 1'b1;
         O_sram_we_n   <= 1'b1;
      end else begin
         ACK_O <= 1'b0;

         // A newer edge simply replaces the pending address; one fetch results.
         if (vid_edge) begin
            vid_adr     <= I_vid_adr;
            vid_pending <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               // An edge arriving this very cycle is served at once, using
               // the live address, so it wins over a simultaneous STB_I.
               if (vid_pending || vid_edge) begin
                  vid_pending <= 1'b0;
                  O_sram_adr  <= vid_edge ? I_vid_adr : vid_adr;
                  O_sram_ce_n <= 1'b0;
                  O_sram_oe_n <= 1'b0;
                  cnt         <= CNT_INIT;
                  state       <= ST_VID_RD;
               end else if (STB_I) begin
                  O_sram_adr  <= ADR_I;
                  O_sram_ce_n <= 1'b0;
                  cnt         <= CNT_INIT;
                  if (WE_I) begin
                     O_sram_dat    <= DAT_I;
                     O_sram_dat_oe <= 1'b1;
                     O_sram_we_n   <= 1'b0;
                     state         <= ST_CPU_WR;
                  end else begin
                     O_sram_oe_n <= 1'b0;
                     state       <= ST_CPU_RD;
                  end
               end
            end

            ST_VID_RD: begin
               if (cnt == 3'd0) begin
                  O_vid_dat   <= I_sram_dat;
                  O_sram_ce_n <= 1'b1;
                  O_sram_oe_n <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end

            ST_CPU_RD: begin
               if (cnt == 3'd0) begin
                  DAT_O       <= I_sram_dat;
                  O_sram_ce_n <= 1'b1;
                  O_sram_oe_n <= 1'b1;
                  ACK_O       <= 1'b1;
                  state       <= ST_CPU_ACK;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end

            ST_CPU_WR: begin
               if (cnt == 3'd0) begin
                  O_sram_we_n <= 1'b1;
                  state       <= ST_CPU_WR_HOLD;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end

            ST_CPU_WR_HOLD: begin
               O_sram_dat_oe <= 1'b0;
               O_sram_ce_n   <= 1'b1;
               ACK_O         <= 1'b1;
               state         <= ST_CPU_ACK;
            end

            ST_CPU_ACK: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
